fifo_wr: RTL and testbench

- Write-side pointer and flag controller of the async FIFO, in the write clock domain.
- Counterpart of the read-side controller:
  - owns the binary and Gray write pointers;
  - drives the dual-port memory write address and write enable;
  - compares the next Gray write pointer with the synchronized Gray read pointer to produce a registered full flag.
- Also provides a conservative fill level, an almost-full flag and a sticky overflow flag for the system controller.

---
 rtl/fifo_wr_pkg.sv | 26 ++
 rtl/fifo_gray2bin.sv | 16 +
 rtl/fifo_wr.sv | 84 ++++++++
 tb/tb_fifo_wr.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_pkg.sv
// Shared definitions for the async FIFO: pointer width and Gray/binary
// conversion helpers used by the write side, the read side and the
// synchronizer.
package fifo_wr_pkg;

    // Pointer width shared by both FIFO domains (one extra wrap bit).
    localparam int FIFO_P_SIZE = 4;

    // Binary to Gray on a 32-bit carrier. A zero-extended narrower pointer
    // converts correctly because the upper zeros leave the low bits untouched.
    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    // Gray to binary: XOR prefix taken from the MSB downwards. Zero-extended
    // narrower inputs convert correctly for the same reason as above.
    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b[31] = g[31];
        for (int i = 30; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Combinational Gray-to-binary converter of configurable width.
module fifo_gray2bin
    import fifo_wr_pkg::*;
#(
    parameter int WIDTH = FIFO_P_SIZE
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    // Convert through the shared 32-bit helper and keep the low WIDTH bits.
    always_comb begin
        bin = WIDTH'(gray2bin(32'(gray)));
    end

endmodule

// File: rtl/fifo_wr.sv
// Write-side pointer and flag controller of the async FIFO (w_clk domain).
// Owns the binary/Gray write pointers, drives the memory write port and
// produces registered full, almost-full, level and sticky overflow flags.
//
// Handshake: w_inc is a write request and !full is its ready. A write is
// accepted (w_en=1) exactly in a cycle where w_inc=1 and full=0; a request
// while full is dropped and recorded in the sticky overflow flag.
module fifo_wr
    import fifo_wr_pkg::*;
#(
    parameter int P_SIZE    = FIFO_P_SIZE,
    parameter int AF_THRESH = 6
) (
    input  logic              w_clk,
    input  logic              w_rstn,
    input  logic              w_inc,
    input  logic              ovf_clr,
    input  logic [P_SIZE-1:0] sync_rd_ptr,
    output logic              w_en,
    output logic [P_SIZE-2:0] wr_addr,
    output logic [P_SIZE-1:0] gray_wr_ptr,
    output logic              full,
    output logic              almost_full,
    output logic [P_SIZE-1:0] w_level,
    output logic              overflow
);

    logic [P_SIZE-1:0] binary_ptr;
    logic [P_SIZE-1:0] bin_next;
    logic [P_SIZE-1:0] gray_next;
    logic [P_SIZE-1:0] full_target;
    logic [P_SIZE-1:0] rd_bin;
    logic [P_SIZE-1:0] level_next;

    // Read pointer back to binary so the level can be a plain subtraction.
    fifo_gray2bin #(
        .WIDTH (P_SIZE)
    ) u_rd_g2b (
        .gray (sync_rd_ptr),
        .bin  (rd_bin)
    );

    // Accept logic, next pointers, full-compare target and next level.
    always_comb begin
        w_en        = w_inc & ~full;
        bin_next    = binary_ptr + {{(P_SIZE-1){1'b0}}, w_en};
        gray_next   = P_SIZE'(bin2gray(32'(bin_next)));
        // Full when the write pointer is one lap ahead: in Gray this means the
        // two MSBs are inverted and the rest equal.
        full_target = {~sync_rd_ptr[P_SIZE-1:P_SIZE-2], sync_rd_ptr[P_SIZE-3:0]};
        level_next  = bin_next - rd_bin;
    end

    assign wr_addr = binary_ptr[P_SIZE-2:0];

    // Pointer, full, level and almost-full registers.
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            binary_ptr  <= '0;
            gray_wr_ptr <= '0;
            full        <= 1'b0;
            w_level     <= '0;
            almost_full <= 1'b0;
        end else begin
            binary_ptr  <= bin_next;
            gray_wr_ptr <= gray_next;
            full        <= (gray_next == full_target);
            w_level     <= level_next;
            almost_full <= (32'(level_next) >= 32'(AF_THRESH));
        end
    end

    // Sticky overflow: a rejected write sets it, ovf_clr clears, set wins.
    always_ff @(posedge w_clk or negedge w_rstn) begin
        if (!w_rstn) begin
            overflow <= 1'b0;
        end else if (w_inc && full) begin
            overflow <= 1'b1;
        end else if (ovf_clr) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fifo_wr.sv
// Directed bench for the async FIFO write-side controller (P_SIZE=4, AF_THRESH=6).
module tb_fifo_wr;

    logic       w_clk;
    logic       w_rstn;
    logic       w_inc;
    logic       ovf_clr;
    logic [3:0] sync_rd_ptr;
    logic       w_en;
    logic [2:0] wr_addr;
    logic [3:0] gray_wr_ptr;
    logic       full;
    logic       almost_full;
    logic [3:0] w_level;
    logic       overflow;

    int n_cmp = 0;
    int n_err = 0;

    fifo_wr #(
        .P_SIZE    (4),
        .AF_THRESH (6)
    ) dut (
        .w_clk       (w_clk),
        .w_rstn      (w_rstn),
        .w_inc       (w_inc),
        .ovf_clr     (ovf_clr),
        .sync_rd_ptr (sync_rd_ptr),
        .w_en        (w_en),
        .wr_addr     (wr_addr),
        .gray_wr_ptr (gray_wr_ptr),
        .full        (full),
        .almost_full (almost_full),
        .w_level     (w_level),
        .overflow    (overflow)
    );

    // Clock: 10 ns period.
    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    function automatic logic [3:0] to_gray(input logic [3:0] b);
        return b ^ (b >> 1);
    endfunction

    // Advance one active edge and settle 1 ns past it.
    task automatic tick();
        @(posedge w_clk);
        #1;
    endtask

    task automatic test_reset();
        w_rstn = 1'b0; w_inc = 1'b0; ovf_clr = 1'b0; sync_rd_ptr = 4'd0;
        tick(); tick();
        w_rstn = 1'b1;
        tick();
        n_cmp++; if (full !== 1'b0)        begin n_err++; $display("FAIL rst_full got %b exp 0", full); end
        n_cmp++; if (almost_full !== 1'b0) begin n_err++; $display("FAIL rst_af got %b exp 0", almost_full); end
        n_cmp++; if (w_level !== 4'd0)     begin n_err++; $display("FAIL rst_level got %0d exp 0", w_level); end
        n_cmp++; if (overflow !== 1'b0)    begin n_err++; $display("FAIL rst_ovf got %b exp 0", overflow); end
        n_cmp++; if (wr_addr !== 3'd0)     begin n_err++; $display("FAIL rst_addr got %0d exp 0", wr_addr); end
        n_cmp++; if (gray_wr_ptr !== 4'd0) begin n_err++; $display("FAIL rst_gray got %b exp 0000", gray_wr_ptr); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            w_inc = 1'b1;
            #1;
            n_cmp++; if (wr_addr !== 3'(i)) begin n_err++; $display("FAIL fill_addr[%0d] got %0d exp %0d", i, wr_addr, i); end
            n_cmp++; if (w_en !== 1'b1)     begin n_err++; $display("FAIL fill_wen[%0d] got %b exp 1", i, w_en); end
            tick();
            n_cmp++; if (w_level !== 4'(i + 1)) begin n_err++; $display("FAIL fill_level[%0d] got %0d exp %0d", i, w_level, i + 1); end
            n_cmp++; if (almost_full !== (i >= 5)) begin n_err++; $display("FAIL fill_af[%0d] got %b exp %b", i, almost_full, (i >= 5)); end
            n_cmp++; if (full !== (i == 7)) begin n_err++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, (i == 7)); end
        end
        w_inc = 1'b0;
        n_cmp++; if (gray_wr_ptr !== 4'b1100) begin n_err++; $display("FAIL fill_gray got %b exp 1100", gray_wr_ptr); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 2; i++) begin
            w_inc = 1'b1;
            #1;
            n_cmp++; if (w_en !== 1'b0) begin n_err++; $display("FAIL ovf_wen[%0d] got %b exp 0", i, w_en); end
            tick();
            n_cmp++; if (gray_wr_ptr !== 4'b1100) begin n_err++; $display("FAIL ovf_gray[%0d] got %b exp 1100", i, gray_wr_ptr); end
            n_cmp++; if (wr_addr !== 3'd0) begin n_err++; $display("FAIL ovf_addr[%0d] got %0d exp 0", i, wr_addr); end
            n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set[%0d] got %b exp 1", i, overflow); end
            n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL ovf_full[%0d] got %b exp 1", i, full); end
        end
        w_inc = 1'b0; ovf_clr = 1'b1;
        tick();
        n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL ovf_clr got %b exp 0", overflow); end
        w_inc = 1'b1; ovf_clr = 1'b1;
        tick();
        n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_set_wins got %b exp 1", overflow); end
        n_cmp++; if (w_level !== 4'd8) begin n_err++; $display("FAIL ovf_level got %0d exp 8", w_level); end
        w_inc = 1'b0; ovf_clr = 1'b0;
    endtask

    task automatic test_wrap();
        sync_rd_ptr = 4'b0001;
        tick();
        n_cmp++; if (full !== 1'b0)    begin n_err++; $display("FAIL wrap_clear got %b exp 0", full); end
        n_cmp++; if (w_level !== 4'd7) begin n_err++; $display("FAIL wrap_level got %0d exp 7", w_level); end
        w_inc = 1'b1;
        #1;
        n_cmp++; if (wr_addr !== 3'd0) begin n_err++; $display("FAIL wrap_addr got %0d exp 0", wr_addr); end
        tick();
        w_inc = 1'b0;
        n_cmp++; if (full !== 1'b1) begin n_err++; $display("FAIL wrap_refull got %b exp 1", full); end
        n_cmp++; if (gray_wr_ptr !== 4'b1101) begin n_err++; $display("FAIL wrap_gray got %b exp 1101", gray_wr_ptr); end
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_bin;
        logic [3:0] prev_gray;
        exp_bin = 4'd9;
        // Reader catches up to 2 behind the writer.
        sync_rd_ptr = to_gray(4'd7);
        tick();
        n_cmp++; if (full !== 1'b0)    begin n_err++; $display("FAIL b2b_prep_full got %b exp 0", full); end
        n_cmp++; if (w_level !== 4'd2) begin n_err++; $display("FAIL b2b_prep_level got %0d exp 2", w_level); end
        for (int i = 0; i < 40; i++) begin
            prev_gray   = gray_wr_ptr;
            sync_rd_ptr = to_gray(exp_bin - 4'd1);
            w_inc       = 1'b1;
            tick();
            exp_bin = exp_bin + 4'd1;
            n_cmp++; if (full !== 1'b0)    begin n_err++; $display("FAIL b2b_full[%0d] got %b exp 0", i, full); end
            n_cmp++; if (w_level !== 4'd2) begin n_err++; $display("FAIL b2b_level[%0d] got %0d exp 2", i, w_level); end
            n_cmp++; if (gray_wr_ptr !== to_gray(exp_bin)) begin n_err++; $display("FAIL b2b_gray[%0d] got %b exp %b", i, gray_wr_ptr, to_gray(exp_bin)); end
            n_cmp++; if ($countones(gray_wr_ptr ^ prev_gray) != 1) begin n_err++; $display("FAIL b2b_onebit[%0d] got %b->%b exp one-bit step", i, prev_gray, gray_wr_ptr); end
        end
        w_inc = 1'b0;
    endtask

    task automatic test_async_reset();
        // Writer currently at binary 1; park the reader there, then write 5.
        sync_rd_ptr = to_gray(4'd1);
        tick();
        for (int i = 0; i < 5; i++) begin
            w_inc = 1'b1;
            tick();
        end
        n_cmp++; if (w_level !== 4'd5) begin n_err++; $display("FAIL ar_level_pre got %0d exp 5", w_level); end
        #2;
        w_rstn = 1'b0;
        #1;
        n_cmp++; if (w_level !== 4'd0)     begin n_err++; $display("FAIL ar_level got %0d exp 0", w_level); end
        n_cmp++; if (gray_wr_ptr !== 4'd0) begin n_err++; $display("FAIL ar_gray got %b exp 0000", gray_wr_ptr); end
        n_cmp++; if (wr_addr !== 3'd0)     begin n_err++; $display("FAIL ar_addr got %0d exp 0", wr_addr); end
        n_cmp++; if (full !== 1'b0 || almost_full !== 1'b0 || overflow !== 1'b0) begin n_err++; $display("FAIL ar_flags got %b%b%b exp 000", full, almost_full, overflow); end
        n_cmp++; if (w_en !== 1'b1) begin n_err++; $display("FAIL ar_wen got %b exp 1", w_en); end
        sync_rd_ptr = 4'd0;
        tick();
        w_rstn = 1'b1;
        #1;
        n_cmp++; if (wr_addr !== 3'd0) begin n_err++; $display("FAIL ar_first_addr got %0d exp 0", wr_addr); end
        tick();
        w_inc = 1'b0;
        n_cmp++; if (gray_wr_ptr !== 4'b0001) begin n_err++; $display("FAIL ar_first_gray got %b exp 0001", gray_wr_ptr); end
        n_cmp++; if (wr_addr !== 3'd1) begin n_err++; $display("FAIL ar_next_addr got %0d exp 1", wr_addr); end
        n_cmp++; if (w_level !== 4'd1) begin n_err++; $display("FAIL ar_first_level got %0d exp 1", w_level); end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_overflow();
        test_wrap();
        test_back_to_back();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
